// File: rtl/seg7_pkg.sv
// Shared glyph codes and seven-segment patterns for the display scanner.
// Patterns are active-high and ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int GLYPH_W = 5;
    localparam int SEG_W   = 7;

    localparam logic [GLYPH_W-1:0] GLYPH_BLANK = 5'h10;
    localparam logic [GLYPH_W-1:0] GLYPH_DASH  = 5'h11;
    localparam logic [GLYPH_W-1:0] GLYPH_L     = 5'h12;
    localparam logic [GLYPH_W-1:0] GLYPH_H     = 5'h13;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_A     = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B     = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_C     = 7'h39;
    localparam logic [SEG_W-1:0] SEG_D     = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_E     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_F     = 7'h71;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;
    localparam logic [SEG_W-1:0] SEG_L     = 7'h38;
    localparam logic [SEG_W-1:0] SEG_H     = 7'h76;

    function automatic logic [SEG_W-1:0] seg_polar(
        input logic [SEG_W-1:0] pat,
        input logic             active_low
    );
        return active_low ? ~pat : pat;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational glyph-code to active-high segment pattern decoder.
// Unassigned codes fall through to an all-dark pattern.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [GLYPH_W-1:0] code_i,
    output logic [SEG_W-1:0]   pat_o
);

    always_comb begin
        pat_o = SEG_BLANK;
        case (code_i)
            5'h00:       pat_o = SEG_0;
            5'h01:       pat_o = SEG_1;
            5'h02:       pat_o = SEG_2;
            5'h03:       pat_o = SEG_3;
            5'h04:       pat_o = SEG_4;
            5'h05:       pat_o = SEG_5;
            5'h06:       pat_o = SEG_6;
            5'h07:       pat_o = SEG_7;
            5'h08:       pat_o = SEG_8;
            5'h09:       pat_o = SEG_9;
            5'h0A:       pat_o = SEG_A;
            5'h0B:       pat_o = SEG_B;
            5'h0C:       pat_o = SEG_C;
            5'h0D:       pat_o = SEG_D;
            5'h0E:       pat_o = SEG_E;
            5'h0F:       pat_o = SEG_F;
            GLYPH_BLANK: pat_o = SEG_BLANK;
            GLYPH_DASH:  pat_o = SEG_DASH;
            GLYPH_L:     pat_o = SEG_L;
            GLYPH_H:     pat_o = SEG_H;
            default:     pat_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scanner.sv
// Multiplexed seven-segment scanner with frame snapshots, leading-zero
// suppression, per-digit blanking and PWM brightness.
module seg7_scanner
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS       = 8,
    parameter int REFRESH_DIV      = 100000,
    parameter int PWM_BITS         = 4,
    parameter bit ANODE_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW   = 1'b1,
    localparam int IW              = $clog2(NUM_DIGITS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [GLYPH_W*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic [NUM_DIGITS-1:0]         blank_in,
    input  logic                          lzs_en,
    input  logic [PWM_BITS-1:0]           brightness,
    output logic [SEG_W-1:0]              seg,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          frame_start,
    output logic [IW-1:0]                 cur_digit
);

    localparam int PW = $clog2(REFRESH_DIV);

    localparam logic [PW-1:0] P_LAST   = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] P_GUARD  = PW'(2);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    localparam logic [NUM_DIGITS-1:0] AN_OFF  =
        ANODE_ACTIVE_LOW ? '1 : '0;
    localparam logic [SEG_W-1:0]      SEG_OFF =
        SEG_ACTIVE_LOW ? '1 : '0;
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;

    logic [PW-1:0] p_q, p_d;
    logic [IW-1:0] idx_q, idx_d;

    logic [GLYPH_W*NUM_DIGITS-1:0] snap_dig_q, snap_dig_d;
    logic [NUM_DIGITS-1:0]         snap_dp_q, snap_dp_d;
    logic [NUM_DIGITS-1:0]         snap_blank_q, snap_blank_d;
    logic                          snap_lzs_q, snap_lzs_d;

    logic [SEG_W-1:0]      seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  fs_q, fs_d;
    logic [IW-1:0]         cur_q, cur_d;

    logic                  capture;
    logic [GLYPH_W-1:0]    codes [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lead_zero;
    logic [GLYPH_W-1:0]    cur_code;
    logic [SEG_W-1:0]      cur_pat;
    logic                  dark;
    logic                  an_on;
    logic [NUM_DIGITS-1:0] an_hi;
    logic                  run;

    // Position (index 0, p 0) is both the post-reset state and the frame
    // boundary, so one condition covers both snapshot events.
    assign capture = (p_q == '0) && (idx_q == '0);

    always_comb begin
        p_d   = (p_q == P_LAST) ? '0 : p_q + 1'b1;
        idx_d = idx_q;
        if (p_q == P_LAST) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        snap_dig_d   = snap_dig_q;
        snap_dp_d    = snap_dp_q;
        snap_blank_d = snap_blank_q;
        snap_lzs_d   = snap_lzs_q;
        if (capture) begin
            snap_dig_d   = digits_in;
            snap_dp_d    = dp_in;
            snap_blank_d = blank_in;
            snap_lzs_d   = lzs_en;
        end
    end

    // The output stage decodes from the incoming snapshot so the first slot
    // of a frame already shows the freshly captured inputs.
    always_comb begin
        run       = 1'b1;
        lead_zero = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            codes[i] = snap_dig_d[GLYPH_W*i +: GLYPH_W];
        end
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run          = run & (codes[i] == '0);
            lead_zero[i] = run;
        end
    end

    assign cur_code = codes[idx_q];

    seg7_decode u_decode (
        .code_i (cur_code),
        .pat_o  (cur_pat)
    );

    always_comb begin
        dark = snap_blank_d[idx_q]
             | (snap_lzs_d & lead_zero[idx_q] & (idx_q != '0));

        an_on = (p_q >= P_GUARD)
             && (p_q[PWM_BITS-1:0] <= brightness);
        an_hi        = '0;
        an_hi[idx_q] = an_on;

        seg_d = seg_polar(dark ? SEG_BLANK : cur_pat, SEG_ACTIVE_LOW);
        dp_d  = (snap_dp_d[idx_q] & ~snap_blank_d[idx_q]) ^ SEG_ACTIVE_LOW;
        an_d  = ANODE_ACTIVE_LOW ? ~an_hi : an_hi;
        fs_d  = capture;
        cur_d = idx_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q          <= '0;
            idx_q        <= '0;
            snap_dig_q   <= '0;
            snap_dp_q    <= '0;
            snap_blank_q <= '1;
            snap_lzs_q   <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= AN_OFF;
            fs_q         <= 1'b0;
            cur_q        <= '0;
        end else begin
            p_q          <= p_d;
            idx_q        <= idx_d;
            snap_dig_q   <= snap_dig_d;
            snap_dp_q    <= snap_dp_d;
            snap_blank_q <= snap_blank_d;
            snap_lzs_q   <= snap_lzs_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            fs_q         <= fs_d;
            cur_q        <= cur_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign frame_start = fs_q;
    assign cur_digit   = cur_q;

endmodule

// File: tb/tb_seg7_scanner.sv
// Directed table-driven bench for seg7_scanner at 4 digits, 8-cycle slots,
// 2-bit PWM and active-low pins.
module tb_seg7_scanner;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int PB = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [19:0]   digits_in;
    logic [ND-1:0] dp_in;
    logic [ND-1:0] blank_in;
    logic          lzs_en;
    logic [PB-1:0] brightness;
    logic [6:0]    seg;
    logic          dp;
    logic [ND-1:0] an;
    logic          frame_start;
    logic [1:0]    cur_digit;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seg7_scanner #(
        .NUM_DIGITS       (ND),
        .REFRESH_DIV      (RD),
        .PWM_BITS         (PB),
        .ANODE_ACTIVE_LOW (1'b1),
        .SEG_ACTIVE_LOW   (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .lzs_en      (lzs_en),
        .brightness  (brightness),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start),
        .cur_digit   (cur_digit)
    );

    typedef struct {
        logic [19:0]      digits;
        logic [3:0]       dpi;
        logic [3:0]       blank;
        logic             lzs;
        logic [1:0]       bright;
        logic [3:0][6:0]  seg_e;
        logic [3:0]       dp_e;
        logic [7:0]       an_mask;
    } vec_t;

    vec_t tbl [6];
    vec_t coh;

    function automatic vec_t mkv(
        input logic [19:0]     d,
        input logic [3:0]      dpi,
        input logic [3:0]      blk,
        input logic            lzs,
        input logic [1:0]      br,
        input logic [3:0][6:0] se,
        input logic [3:0]      de,
        input logic [7:0]      am
    );
        vec_t v;
        v.digits  = d;
        v.dpi     = dpi;
        v.blank   = blk;
        v.lzs     = lzs;
        v.bright  = br;
        v.seg_e   = se;
        v.dp_e    = de;
        v.an_mask = am;
        return v;
    endfunction

    task automatic chk(input string nm, input int c,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc %0d: got %h want %h", nm, c, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " an"}, 0, 32'(an), 32'hF);
        chk({tag, " seg"}, 0, 32'(seg), 32'h7F);
        chk({tag, " dp"}, 0, 32'(dp), 32'h1);
        chk({tag, " frame_start"}, 0, 32'(frame_start), 32'h0);
        chk({tag, " cur_digit"}, 0, 32'(cur_digit), 32'h0);
    endtask

    // Entered at a falling edge just before the capture edge of a frame.
    task automatic run_frame(input vec_t v, input int ncyc,
                             input int chg_at, input logic [19:0] chg_dig);
        int s;
        int p;
        logic [3:0] exp_an;
        digits_in  = v.digits;
        dp_in      = v.dpi;
        blank_in   = v.blank;
        lzs_en     = v.lzs;
        brightness = v.bright;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            @(negedge clk);
            s = c / RD;
            p = c % RD;
            exp_an = v.an_mask[p] ? ~(4'b0001 << s) : 4'hF;
            chk("cur_digit", c, 32'(cur_digit), 32'(s));
            chk("frame_start", c, 32'(frame_start), 32'(c == 0));
            chk("an", c, 32'(an), 32'(exp_an));
            chk("seg", c, 32'(seg), 32'(v.seg_e[s]));
            chk("dp", c, 32'(dp), 32'(v.dp_e[s]));
            if (c == chg_at) digits_in = chg_dig;
        end
    endtask

    initial begin
        tbl[0] = mkv({5'h03, 5'h02, 5'h01, 5'h00}, 4'h0, 4'h0, 1'b0, 2'd3,
                     {7'h30, 7'h24, 7'h79, 7'h40}, 4'hF, 8'hFC);
        tbl[1] = mkv({5'h13, 5'h12, 5'h11, 5'h0F}, 4'h0, 4'h0, 1'b0, 2'd0,
                     {7'h09, 7'h47, 7'h3F, 7'h0E}, 4'hF, 8'h10);
        tbl[2] = mkv({5'h00, 5'h00, 5'h05, 5'h00}, 4'h0, 4'h0, 1'b1, 2'd1,
                     {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF, 8'h30);
        tbl[3] = mkv({5'h00, 5'h00, 5'h00, 5'h00}, 4'b1010, 4'h0, 1'b1, 2'd2,
                     {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0101, 8'h74);
        tbl[4] = mkv({5'h0A, 5'h08, 5'h1F, 5'h10}, 4'b0101, 4'b0100, 1'b0,
                     2'd3, {7'h08, 7'h7F, 7'h7F, 7'h7F}, 4'b1110, 8'hFC);
        tbl[5] = mkv({5'h00, 5'h01, 5'h00, 5'h00}, 4'h0, 4'h0, 1'b1, 2'd3,
                     {7'h7F, 7'h79, 7'h40, 7'h40}, 4'hF, 8'hFC);
        coh    = mkv({5'h08, 5'h07, 5'h06, 5'h05}, 4'h0, 4'h0, 1'b0, 2'd3,
                     {7'h00, 7'h78, 7'h02, 7'h12}, 4'hF, 8'hFC);

        reset      = 1'b1;
        digits_in  = '0;
        dp_in      = '0;
        blank_in   = '0;
        lzs_en     = 1'b0;
        brightness = '0;
        repeat (3) @(negedge clk);
        chk_reset("reset-hold");
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i], ND * RD, -1, '0);
        end

        // Mid-frame input change must wait for the next frame.
        run_frame(tbl[0], ND * RD, RD + 2, coh.digits);
        run_frame(coh, ND * RD, -1, '0);

        // Asynchronous reset at slot 2, p 5.
        run_frame(tbl[1], 2 * RD + 6, -1, '0);
        reset = 1'b1;
        #1;
        chk_reset("async-reset");
        repeat (2) @(negedge clk);
        chk_reset("async-hold");
        reset = 1'b0;
        run_frame(tbl[2], ND * RD, -1, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg7_scanner.md
# seg7_scanner

Parametrised multiplexed seven-segment display scanner for the Nexys4 top level. It replaces the fixed 8-digit driver with configurable digit count and refresh rate. It adds frame-coherent input snapshotting, leading-zero suppression, per-digit blanking and PWM brightness control. It drives the board's cathode (`seg`, `dp`) and anode (`an`) pins directly.

## Interface
Parameters:
- `NUM_DIGITS`, 8: digits scanned; must be >= 2.
- `REFRESH_DIV`, 100000: clk cycles per digit slot; must be >= 4 and a multiple of 2^`PWM_BITS`.
- `PWM_BITS`, 4: brightness resolution.
- `ANODE_ACTIVE_LOW`, 1: anode polarity.
- `SEG_ACTIVE_LOW`, 1: cathode and `dp` polarity.

Ports:
- `clk` in 1: 100 MHz system clock; the block uses one clock.
- `reset` in 1: asynchronous, active-high reset.
- `digits_in` in 5*`NUM_DIGITS`: 5-bit glyph code per digit; digit 0 is the least-significant field and the rightmost digit.
- `dp_in` in `NUM_DIGITS`: decimal point request per digit.
- `blank_in` in `NUM_DIGITS`: force digit dark.
- `lzs_en` in 1: leading-zero suppression enable.
- `brightness` in `PWM_BITS`: duty level; 0 is dimmest, all-ones is full.
- `seg` out 7: cathodes, ordered {g,f,e,d,c,b,a}.
- `dp` out 1: decimal point cathode.
- `an` out `NUM_DIGITS`: anodes.
- `frame_start` out 1: one-cycle pulse when a new frame begins.
- `cur_digit` out $clog2(`NUM_DIGITS`): index of the digit being scanned.

## Operation
- Prescaler `p` counts 0..`REFRESH_DIV`-1 and wraps to 0.
- Digit index advances when `p`==`REFRESH_DIV`-1. It wraps from `NUM_DIGITS`-1 to 0.
- Snapshot registers capture `digits_in`, `dp_in`, `blank_in` and `lzs_en`:
  - on the first edge after `reset` deasserts;
  - on every index wrap to 0.
- `frame_start` pulses in the cycle the snapshot becomes valid. Inputs are never sampled mid-frame.
- Glyph codes:
  - 0x00-0x0F: hex 0-F.
  - 0x10: blank.
  - 0x11: '-'.
  - 0x12: 'L'.
  - 0x13: 'H'.
  - 0x14-0x1F: blank.
- Leading-zero suppression applies when snapshot `lzs_en`=1. Digit i >= 1 is dark if digits `NUM_DIGITS`-1 down to i all hold code 0x00. Digit 0 is never suppressed.
- `dp` follows snapshot `dp_in` even on suppressed digits. It is forced off on `blank_in` digits.
- The anode of the current digit is active only when both hold:
  - guard: `p` >= 2 (anti-ghosting guard);
  - PWM: `p`[`PWM_BITS`-1:0] <= `brightness`.
- `brightness` is sampled live, not snapshotted.
- All other anodes are inactive.
- A dark digit (blank, suppressed or blank glyph) drives all segments off. Its anode still follows the guard and PWM rule.

## Timing
- `seg`, `dp`, `an` and `cur_digit` are registered. They reflect the (index, `p`) of the previous cycle, so latency is 1 clk.
- `frame_start` is asserted in the cycle `cur_digit` first shows 0 for the new frame.
- Frame period is `NUM_DIGITS`*`REFRESH_DIV` cycles: 8 ms at the defaults.
- Reset values, forced immediately on `reset` assertion including mid-frame:
  - `an` all inactive;
  - `seg` all off;
  - `dp` off;
  - `frame_start` 0;
  - `cur_digit` 0;
  - `p` 0 and index 0;
  - snapshot: digits 0, `blank_in` all ones, `dp_in` 0, `lzs_en` 0.
- Input changes never alter segments within the current frame; only `brightness` takes effect inside a frame.

## Structure
- Package `seg7_pkg` holds:
  - glyph code constants (`GLYPH_BLANK`, `GLYPH_DASH`, `GLYPH_L`, `GLYPH_H`);
  - active-high 7-bit segment pattern constants for each glyph.
- Sub-module `seg7_decode`: combinational 5-bit code to active-high pattern. Polarity inversion happens in `seg7_scanner` at the output register.
- The prescaler, scan index, snapshot, LZS and PWM logic live in `seg7_scanner`.

## Test plan
Bench parameters: `NUM_DIGITS`=4, `REFRESH_DIV`=8, `PWM_BITS`=2, active-low polarity.
- Reset held, then released with `digits_in`={0x3,0x2,0x1,0x0} and `brightness`=3:
  - `frame_start` pulses once;
  - `cur_digit` sequence is 0,1,2,3 with 8 cycles each;
  - `an`=4'b1110 at `p`=2..7 of slot 0;
  - `seg`=7'b1000000 ('0') in slot 0.
- Brightness and guard: `brightness`=0 -> `an` active only at `p`=4 of each slot; `brightness`=1 -> `p`=4,5.
- Leading-zero suppression: `lzs_en`=1, digits {0x0,0x0,0x5,0x0}:
  - digits 3 and 2 show `seg`=7'h7F;
  - digit 1 shows '5' (7'b0010010);
  - digit 0 shows '0'.
- Snapshot coherency: change `digits_in` during slot 1 -> segments unchanged until the next `frame_start`, then show the new value.
- Special glyphs: code 0x11 gives `seg`=7'b0111111; `blank_in`[2]=1 with `dp_in`[2]=1 gives `seg`=7'h7F and `dp`=1.
- Asynchronous reset asserted at `p`=5 of slot 2:
  - same cycle: `an`=4'hF, `seg`=7'h7F, `cur_digit`=0;
  - after release: restart with a `frame_start` pulse.
